issue_scoreboard: RTL and testbench

- Issue controller between decode and EX for the in-order RV32 core.
- Holds one decoded instruction in an issue register with valid/ready handshakes on both sides.
- Tracks in-flight destination registers in a 32-entry busy bitmap and stalls decode on RAW and WAW hazards until writeback clears the register.
- Provides stall statistics and a sticky protocol-error flag.

---
 rtl/issue_scoreboard.sv | 156 +++++++++++++++
 tb/tb_issue_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue register between decode and EX with a busy-register scoreboard.
// Stalls decode on RAW/WAW hazards against registers still awaiting writeback.
module issue_scoreboard #(
  parameter int XLEN    = 32,
  parameter int STALL_W = 16,
  localparam int AW     = $clog2(XLEN),
  localparam int NREG   = 1 << AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [3:0]         dec_operation,
  input  logic [AW-1:0]      dec_src1,
  input  logic [AW-1:0]      dec_src2,
  input  logic [AW-1:0]      dec_dest,
  input  logic [XLEN-1:0]    dec_imm,
  input  logic               dec_use_imm,
  input  logic               dec_is_load_store,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [3:0]         iss_operation,
  output logic [AW-1:0]      iss_src1,
  output logic [AW-1:0]      iss_src2,
  output logic [AW-1:0]      iss_dest,
  output logic [XLEN-1:0]    iss_imm,
  output logic               iss_use_imm,
  output logic               iss_is_load_store,
  output logic               iss_writes_rd,
  input  logic               wb_valid,
  input  logic [AW-1:0]      wb_dest,
  output logic [5:0]         busy_count,
  output logic [STALL_W-1:0] stall_count,
  output logic               sb_err
);

  localparam logic [3:0] OP_SW = 4'b1001;

  logic               r_iss_valid;
  logic [3:0]         r_iss_operation;
  logic [AW-1:0]      r_iss_src1;
  logic [AW-1:0]      r_iss_src2;
  logic [AW-1:0]      r_iss_dest;
  logic [XLEN-1:0]    r_iss_imm;
  logic               r_iss_use_imm;
  logic               r_iss_is_load_store;
  logic               r_iss_writes_rd;
  logic [NREG-1:0]    r_busy;
  logic [5:0]         r_busy_count;
  logic [STALL_W-1:0] r_stall_count;
  logic               r_sb_err;

  logic               w_is_sw;
  logic               w_writes_rd;
  logic               w_use_rs2;
  logic               w_raw;
  logic               w_waw;
  logic               w_hazard;
  logic               w_ready;
  logic               w_accept;
  logic               w_set;
  logic               w_wb_hit;
  logic [NREG-1:0]    w_set_vec;
  logic [NREG-1:0]    w_clr_vec;
  logic [NREG-1:0]    w_busy_nxt;
  logic               w_stall;

  always_comb begin
    w_is_sw     = dec_is_load_store && (dec_operation == OP_SW);
    w_writes_rd = !w_is_sw;
    // SW reads rs2 as store data even though its immediate feeds the address
    w_use_rs2   = !dec_use_imm || w_is_sw;
    w_raw       = r_busy[dec_src1] || (w_use_rs2 && r_busy[dec_src2]);
    w_waw       = w_writes_rd && (dec_dest != '0) && r_busy[dec_dest];
    w_hazard    = w_raw || w_waw;
    w_ready     = (!r_iss_valid || iss_ready) && !w_hazard;
    w_accept    = dec_valid && w_ready;
    w_stall     = dec_valid && !w_ready;
  end

  always_comb begin
    w_set     = w_accept && w_writes_rd && (dec_dest != '0);
    w_wb_hit  = wb_valid && (wb_dest != '0) && r_busy[wb_dest];
    w_set_vec = '0;
    w_clr_vec = '0;
    if (w_set)    w_set_vec = NREG'(1) << dec_dest;
    if (w_wb_hit) w_clr_vec = NREG'(1) << wb_dest;
    w_busy_nxt    = (r_busy | w_set_vec) & ~w_clr_vec;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_valid         <= 1'b0;
      r_iss_operation     <= '0;
      r_iss_src1          <= '0;
      r_iss_src2          <= '0;
      r_iss_dest          <= '0;
      r_iss_imm           <= '0;
      r_iss_use_imm       <= 1'b0;
      r_iss_is_load_store <= 1'b0;
      r_iss_writes_rd     <= 1'b0;
    end else if (w_accept) begin
      r_iss_valid         <= 1'b1;
      r_iss_operation     <= dec_operation;
      r_iss_src1          <= dec_src1;
      r_iss_src2          <= dec_src2;
      r_iss_dest          <= dec_dest;
      r_iss_imm           <= dec_imm;
      r_iss_use_imm       <= dec_use_imm;
      r_iss_is_load_store <= dec_is_load_store;
      r_iss_writes_rd     <= w_writes_rd;
    end else if (iss_ready) begin
      r_iss_valid         <= 1'b0;
    end
  end

  // Set and clear never target the same register, so the count moves by at most one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
      r_sb_err     <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_set && !w_wb_hit)
        r_busy_count <= r_busy_count + 6'd1;
      else if (!w_set && w_wb_hit)
        r_busy_count <= r_busy_count - 6'd1;
      if (wb_valid && !w_wb_hit)
        r_sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_count <= '0;
    else if (w_stall && (r_stall_count != '1))
      r_stall_count <= r_stall_count + 1'b1;
  end

  assign dec_ready         = w_ready;
  assign iss_valid         = r_iss_valid;
  assign iss_operation     = r_iss_operation;
  assign iss_src1          = r_iss_src1;
  assign iss_src2          = r_iss_src2;
  assign iss_dest          = r_iss_dest;
  assign iss_imm           = r_iss_imm;
  assign iss_use_imm       = r_iss_use_imm;
  assign iss_is_load_store = r_iss_is_load_store;
  assign iss_writes_rd     = r_iss_writes_rd;
  assign busy_count        = r_busy_count;
  assign stall_count       = r_stall_count;
  assign sb_err            = r_sb_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios then random traffic, all checked
// against a register-list reference model; a second instance checks stall saturation.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [3:0]  dec_operation;
  logic [4:0]  dec_src1, dec_src2, dec_dest;
  logic [31:0] dec_imm;
  logic        dec_use_imm, dec_is_load_store;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_dest;

  logic        dec_ready, iss_valid, iss_use_imm, iss_is_load_store, iss_writes_rd, sb_err;
  logic [3:0]  iss_operation;
  logic [4:0]  iss_src1, iss_src2, iss_dest;
  logic [31:0] iss_imm;
  logic [5:0]  busy_count;
  logic [15:0] stall_count;

  logic        s_dec_ready, s_iss_valid, s_iss_use_imm, s_iss_is_load_store, s_iss_writes_rd, s_sb_err;
  logic [3:0]  s_iss_operation;
  logic [4:0]  s_iss_src1, s_iss_src2, s_iss_dest;
  logic [31:0] s_iss_imm;
  logic [5:0]  s_busy_count;
  logic [3:0]  s_stall_count;

  always #5 clk = ~clk;

  issue_scoreboard #(.XLEN(32), .STALL_W(16)) u_dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_operation(dec_operation), .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_dest(dec_dest), .dec_imm(dec_imm), .dec_use_imm(dec_use_imm),
    .dec_is_load_store(dec_is_load_store), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_operation(iss_operation), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_dest(iss_dest), .iss_imm(iss_imm), .iss_use_imm(iss_use_imm),
    .iss_is_load_store(iss_is_load_store), .iss_writes_rd(iss_writes_rd),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .busy_count(busy_count),
    .stall_count(stall_count), .sb_err(sb_err)
  );

  issue_scoreboard #(.XLEN(32), .STALL_W(4)) u_sat (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ready(s_dec_ready),
    .dec_operation(dec_operation), .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_dest(dec_dest), .dec_imm(dec_imm), .dec_use_imm(dec_use_imm),
    .dec_is_load_store(dec_is_load_store), .iss_valid(s_iss_valid), .iss_ready(iss_ready),
    .iss_operation(s_iss_operation), .iss_src1(s_iss_src1), .iss_src2(s_iss_src2),
    .iss_dest(s_iss_dest), .iss_imm(s_iss_imm), .iss_use_imm(s_iss_use_imm),
    .iss_is_load_store(s_iss_is_load_store), .iss_writes_rd(s_iss_writes_rd),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .busy_count(s_busy_count),
    .stall_count(s_stall_count), .sb_err(s_sb_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of pending registers plus a copy of the held instruction
  bit          m_busy[32];
  bit          m_valid, m_err, m_wr, m_ui, m_ls;
  logic [3:0]  m_op;
  logic [4:0]  m_s1, m_s2, m_d;
  logic [31:0] m_imm;
  int unsigned m_stall;

  function automatic bit is_store();
    return dec_is_load_store && (dec_operation == 4'b1001);
  endfunction

  function automatic bit model_ready();
    bit sw, reads_rs2, raw, waw;
    sw        = is_store();
    reads_rs2 = !dec_use_imm || sw;
    raw       = m_busy[dec_src1] || (reads_rs2 && m_busy[dec_src2]);
    waw       = !sw && (dec_dest != 0) && m_busy[dec_dest];
    return (!m_valid || iss_ready) && !raw && !waw;
  endfunction

  function automatic int pending_regs();
    int n = 0;
    for (int r = 0; r < 32; r++) if (m_busy[r]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    m_valid = 0; m_err = 0; m_stall = 0;
    m_op = '0; m_s1 = '0; m_s2 = '0; m_d = '0; m_imm = '0; m_ui = 0; m_ls = 0; m_wr = 0;
  endtask

  task automatic model_update(input bit er);
    bit sw;
    if (reset) begin
      model_reset();
    end else begin
      sw = is_store();
      if (dec_valid && !er) m_stall++;
      if (wb_valid) begin
        if (wb_dest != 0 && m_busy[wb_dest]) m_busy[wb_dest] = 1'b0;
        else m_err = 1'b1;
      end
      if (dec_valid && er) begin
        m_valid = 1; m_op = dec_operation; m_s1 = dec_src1; m_s2 = dec_src2; m_d = dec_dest;
        m_imm = dec_imm; m_ui = dec_use_imm; m_ls = dec_is_load_store; m_wr = !sw;
        if (!sw && dec_dest != 0) m_busy[dec_dest] = 1'b1;
      end else if (iss_ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check_regs();
    check("iss_valid", iss_valid, m_valid);
    check("iss_operation", iss_operation, m_op);
    check("iss_src1", iss_src1, m_s1);
    check("iss_src2", iss_src2, m_s2);
    check("iss_dest", iss_dest, m_d);
    check("iss_imm", iss_imm, m_imm);
    check("iss_use_imm", iss_use_imm, m_ui);
    check("iss_is_load_store", iss_is_load_store, m_ls);
    check("iss_writes_rd", iss_writes_rd, m_wr);
    check("busy_count", busy_count, pending_regs());
    check("stall_count", stall_count, (m_stall > 65535) ? 65535 : m_stall);
    check("stall_count_sat4", s_stall_count, (m_stall > 15) ? 15 : m_stall);
    check("sb_err", sb_err, m_err);
  endtask

  // Inputs are driven at the falling edge; one call covers one rising edge
  task automatic step();
    bit er;
    #1;
    er = model_ready();
    check("dec_ready", dec_ready, er);
    @(posedge clk);
    model_update(er);
    @(negedge clk);
    check_regs();
  endtask

  task automatic set_dec(input bit v, input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [31:0] imm, input bit ui, input bit ls);
    dec_valid = v; dec_operation = op; dec_src1 = s1; dec_src2 = s2; dec_dest = d;
    dec_imm = imm; dec_use_imm = ui; dec_is_load_store = ls;
  endtask

  task automatic set_wb(input bit v, input logic [4:0] d);
    wb_valid = v; wb_dest = d;
  endtask

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;

  int unsigned stall_before;
  int          list[$];

  initial begin
    model_reset();
    reset = 1'b1; iss_ready = 1'b1;
    set_dec(1, OP_ADD, 1, 2, 3, 32'h1234, 0, 0);
    set_wb(0, 0);
    @(negedge clk);

    // Reset held with a valid decode
    step(); step();
    check("reset_iss_valid", iss_valid, 0);
    check("reset_busy_count", busy_count, 0);
    check("reset_stall", stall_count, 0);
    check("reset_sb_err", sb_err, 0);
    reset = 1'b0;

    // Load-use: LW x5 then ADD x6,x5,x7
    set_dec(1, OP_LW, 1, 0, 5, 32'h10, 1, 1); step();
    set_dec(1, OP_ADD, 5, 7, 6, 0, 0, 0);
    stall_before = stall_count;
    repeat (3) step();
    check("load_use_stall_cnt", stall_count, stall_before + 3);
    set_wb(1, 5); step();
    set_wb(0, 0); step();
    set_dec(0, OP_ADD, 0, 0, 0, 0, 0, 0); step();
    check("load_use_busy", busy_count, 1);
    set_wb(1, 6); step(); set_wb(0, 0);

    // Store and immediate operand usage
    set_dec(1, OP_LW, 1, 0, 3, 32'h20, 1, 1); step();
    set_dec(1, OP_SW, 1, 3, 12, 32'h0, 1, 1); step(); step();
    set_dec(1, OP_ADD, 1, 3, 4, 32'h55, 1, 0); step();
    set_dec(0, OP_ADD, 0, 0, 0, 0, 0, 0);
    set_wb(1, 3); step();
    set_wb(1, 4); step();
    set_wb(0, 0);
    set_dec(1, OP_SW, 1, 3, 12, 32'h0, 1, 1); step();
    set_dec(0, OP_ADD, 0, 0, 0, 0, 0, 0); step();
    check("sw_no_busy", busy_count, 0);

    // x0 destination, WAW on x9, writeback to x0
    set_dec(1, OP_ADD, 1, 0, 0, 32'h7, 1, 0); step();
    check("x0_not_busy", busy_count, 0);
    set_dec(1, OP_ADD, 0, 0, 9, 0, 0, 0); step();
    set_dec(1, OP_ADD, 1, 2, 9, 0, 0, 0); step(); step(); step();
    set_wb(1, 9); step();
    set_wb(0, 0); step();
    set_dec(0, OP_ADD, 0, 0, 0, 0, 0, 0);
    set_wb(1, 9); step();
    set_wb(1, 0); step();
    check("wb_x0_err", sb_err, 1);
    set_wb(0, 0); step(); step();
    check("err_sticky", sb_err, 1);

    // Back-pressure then streaming at one per cycle
    set_dec(1, OP_ADD, 1, 2, 0, 32'hAAAA, 1, 0); step();
    iss_ready = 1'b0;
    set_dec(1, OP_ADD, 3, 4, 0, 32'hBBBB, 1, 0);
    stall_before = stall_count;
    repeat (4) step();
    check("backpressure_stall", stall_count, stall_before + 4);
    check("backpressure_imm", iss_imm, 32'hAAAA);
    iss_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_dec(1, OP_ADD, 5'(i), 5'(i + 1), 0, 32'h100 + 32'(i), 0, 0);
      step();
    end
    check("stream_imm", iss_imm, 32'h105);
    set_dec(0, OP_ADD, 0, 0, 0, 0, 0, 0);

    // Long hazard to saturate the 4-bit counter
    reset = 1'b1; step(); reset = 1'b0;
    set_dec(1, OP_ADD, 0, 0, 9, 0, 0, 0); step();
    set_dec(1, OP_ADD, 9, 1, 2, 0, 0, 0);
    repeat (20) step();
    check("sat4_stops", s_stall_count, 15);
    check("stall16_runs", stall_count, 20);
    reset = 1'b1; step(); reset = 1'b0;

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      int unsigned kind;
      reset = ($urandom_range(0, 199) == 0);
      kind = $urandom_range(0, 3);
      set_dec($urandom_range(0, 3) != 0,
              (kind == 0) ? OP_LW : (kind == 1) ? OP_SW : 4'($urandom_range(0, 15)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom, 1'($urandom_range(0, 1)),
              (kind < 2) ? 1'b1 : ($urandom_range(0, 3) == 0));
      iss_ready = ($urandom_range(0, 3) != 0);
      list.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) list.push_back(r);
      if (list.size() > 0 && $urandom_range(0, 2) == 0)
        set_wb(1, 5'(list[$urandom_range(0, list.size() - 1)]));
      else if ($urandom_range(0, 149) == 0)
        set_wb(1, 5'($urandom_range(0, 31)));
      else
        set_wb(0, 5'($urandom_range(0, 31)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
